// File: rtl/yarvi_mem_pkg.sv
// rtl/yarvi_mem_pkg.sv - shared widths and loader state for the 72x1024 block RAM
package yarvi_mem_pkg;

  localparam int DATA_W         = 72;
  localparam int ADDR_W         = 10;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/bram_loader_if.sv
// rtl/bram_loader_if.sv - command, byte stream and RAM port-B write bundle of the loader
interface bram_loader_if
  import yarvi_mem_pkg::*;
#(
  parameter int DATA = DATA_W,
  parameter int ADDR = ADDR_W
) ();

  logic            start;
  logic [ADDR-1:0] base;
  logic [ADDR:0]   len;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            wr;
  logic [ADDR-1:0] addr;
  logic [DATA-1:0] din;
  logic            busy;
  logic            done;
  logic [7:0]      sum;

  modport slave (
    input  start, base, len, in_valid, in_data,
    output in_ready, wr, addr, din, busy, done, sum
  );

  modport master (
    output start, base, len, in_valid, in_data,
    input  in_ready, wr, addr, din, busy, done, sum
  );

endinterface

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - little-endian byte-lane packer with running XOR sum
// o_word already carries the byte on i_data in the current lane, so a caller can capture a full word on the last strobe.
module word_assembler
  import yarvi_mem_pkg::*;
#(
  parameter int DATA  = DATA_W,
  parameter int BYTES = BYTES_PER_WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_strobe,
  input  logic [7:0]      i_data,
  output logic [DATA-1:0] o_word,
  output logic            o_full,
  output logic [7:0]      o_sum
);

  localparam int CW = $clog2(BYTES);

  logic [CW-1:0]   r_cnt;
  logic [DATA-1:0] r_word;
  logic [7:0]      r_sum;
  logic [DATA-1:0] w_word;

  always_comb begin
    w_word = r_word;
    for (int k = 0; k < BYTES; k++) begin
      if (r_cnt == CW'(k)) begin
        w_word[8*k +: 8] = i_data;
      end
    end
  end

  assign o_word = w_word;
  assign o_full = (r_cnt == CW'(BYTES - 1));
  assign o_sum  = r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_sum  <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_sum  <= '0;
    end else if (i_strobe) begin
      r_word <= w_word;
      r_sum  <= r_sum ^ i_data;
      r_cnt  <= o_full ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bram_loader.sv
// rtl/bram_loader.sv - fills the block RAM through port B from a byte stream, one 72-bit word per 9 bytes
module bram_loader
  import yarvi_mem_pkg::*;
#(
  parameter int DATA = DATA_W,
  parameter int ADDR = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  bram_loader_if.slave  bus
);

  loader_state_t   r_state;
  logic [ADDR-1:0] r_ptr;
  logic [ADDR:0]   r_remain;
  logic            r_wr;
  logic [ADDR-1:0] r_addr;
  logic [DATA-1:0] r_din;
  logic            r_busy;
  logic            r_done;
  logic            r_in_ready;

  logic            w_xfer;
  logic            w_clear;
  logic [DATA-1:0] w_word;
  logic            w_full;
  logic [7:0]      w_sum;

  assign w_xfer  = bus.in_valid && r_in_ready;
  assign w_clear = (r_state == IDLE) && bus.start;

  word_assembler #(
    .DATA  (DATA),
    .BYTES (DATA / 8)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_strobe (w_xfer),
    .i_data   (bus.in_data),
    .o_word   (w_word),
    .o_full   (w_full),
    .o_sum    (w_sum)
  );

  assign bus.in_ready = r_in_ready;
  assign bus.wr       = r_wr;
  assign bus.addr     = r_addr;
  assign bus.din      = r_din;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum      = w_sum;

  // Outputs are set alongside the state transition so they are all plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_remain   <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_ptr    <= bus.base;
            r_remain <= bus.len;
            r_busy   <= 1'b1;
            if (bus.len == '0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= FILL;
            end
          end
        end
        FILL: begin
          if (w_xfer && w_full) begin
            r_in_ready <= 1'b0;
            r_wr       <= 1'b1;
            r_addr     <= r_ptr;
            r_din      <= w_word;
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          r_wr     <= 1'b0;
          r_ptr    <= r_ptr + ADDR'(1);
          r_remain <= r_remain - (ADDR + 1)'(1);
          if (r_remain == (ADDR + 1)'(1)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= FILL;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bram_loader.md
Name: bram_loader

Overview:
- Upstream fill stage for the 72-bit x 1024-word true-dual-port block RAM; drives that RAM's write port (B).
- Accepts a byte stream over a valid/ready handshake and packs every 9 bytes little-endian into one 72-bit word.
- Writes each word to consecutive addresses starting at a programmed base, for a programmed word count.
- Used for boot-time image load (e.g. from UART) before the core starts reading through port A.

Parameters:
- DATA, 72, word width in bits; must be a multiple of 8.
- ADDR, 10, RAM address width.
- BYTES, DATA/8 (derived, 9), bytes per word.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  single-cycle command; honoured only in IDLE.
- base  input  ADDR  first word address, sampled on accepted start.
- len  input  ADDR+1  words to write (0..1024), sampled on accepted start.
- in_valid  input  1  byte available.
- in_data  input  8  byte payload.
- in_ready  output  1  loader accepts byte this cycle.
- wr  output  1  RAM write enable (port B).
- addr  output  ADDR  RAM address (port B).
- din  output  DATA  RAM write data (port B).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final write.
- sum  output  8  XOR of all bytes accepted since the last accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wr, addr, din, done, sum, byte counter, remaining count and word register all 0; in_ready=0; busy=0.
- A byte transfer occurs when in_valid && in_ready at the clock edge.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start: latch addr pointer=base, remaining=len; clear byte counter and sum.
  - Go to DONE if len==0, else FILL.
- FILL:
  - in_ready=1.
  - On transfer: byte k (k=0..8) goes to word bits [8k+7:8k]; sum ^= in_data; k increments.
  - Transfer of byte 8 moves to WRITE.
  - in_valid gaps simply stall; no timeout.
- WRITE (exactly one cycle):
  - Registered outputs: wr=1, addr=pointer, din=assembled word; in_ready=0.
  - Next cycle: pointer+1, wrapping modulo 2^ADDR (0x3FF -> 0x000); remaining-1.
  - Go to DONE if remaining was 1, else FILL.
- DONE: done=1 for one cycle, then IDLE.
- Timing and throughput:
  - Latency: wr is high in the cycle after the 9th byte's transfer edge.
  - done is high the cycle after the final wr.
  - Peak throughput is 10 cycles per word.
- Output stability:
  - wr=0 outside WRITE.
  - addr and din hold the last written values until the next write; they do not glitch.
- start outside IDLE is ignored; base and len are don't-care except in the accepted start cycle.
- len=1024 with any base writes the entire RAM once, wrapping at most once.
- Reset mid-operation: partial word discarded, no write issued, sum cleared. A following start begins a fresh word at byte 0.
- sum is valid and stable from done until the next accepted start.

Decomposition:
- Shared package yarvi_mem_pkg:
  - DATA_W=72, ADDR_W=10, BYTES_PER_WORD=9.
  - Loader state enum {IDLE, FILL, WRITE, DONE}; reused by the future port-A readback checker.
- One sub-module, word_assembler:
  - Contents: byte-lane counter, shift/lane-insert register, sum accumulator.
  - Interface: byte strobe, clear, full flag.
- The FSM, address pointer and remaining counter stay in bram_loader.

Test Plan:
- Single word: start, base=0x005, len=1, bytes 0x01..0x09 back-to-back -> one wr pulse the cycle after the 9th byte with addr=0x005, din=72'h090807060504030201; done next cycle; sum=0x01.
- Wrap: base=0x3FF, len=2, 18 bytes 0x10..0x21 -> writes at 0x3FF (din=72'h181716151413121110) then at 0x000 (din=72'h212019...1A19); one done pulse.
- Zero length: start with len=0 -> done=1 the cycle after start; no wr; in_ready never asserts; busy high exactly that one cycle.
- Backpressure/gaps: in_valid high every 3rd cycle, plus one byte presented during WRITE -> same din values as the back-to-back case; in_ready=0 during WRITE; the held byte is accepted the following cycle; no byte lost or duplicated.
- Reset mid-word: reset after 4 bytes -> no wr; all outputs 0. Then start base=0x100, len=1 with 9 new bytes -> din contains only the new bytes.
- Start while busy: pulse start with different base/len during FILL -> ignored; writes continue at the original addresses and count.
